// File: rtl/hf_reader_sequencer.sv
// Sequences one ISO14443-A reader exchange (transmit, guard, listen, receive) in 16-cycle bit slots,
// driving the HF datapath mode select and modulation bit and strobing received bits to the packer.
module hf_reader_sequencer #(
  parameter int GUARD_SLOTS   = 8,
  parameter int TIMEOUT_SLOTS = 512,
  parameter int END_SLOTS     = 2,
  parameter int MAX_RX        = 256
) (
  input  logic       osc_clk,
  input  logic       nreset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_len,
  input  logic       tx_bit,
  input  logic       rx_bit,
  output logic [2:0] mod_type,
  output logic       mod_bit,
  output logic       tx_req,
  output logic       rx_data,
  output logic       rx_strobe,
  output logic       rx_sof,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int GW = $clog2(GUARD_SLOTS + 1);
  localparam int TW = $clog2(TIMEOUT_SLOTS + 1);
  localparam int EW = $clog2(END_SLOTS + 1);
  localparam int RW = $clog2(MAX_RX + 1);

  localparam logic [GW-1:0] GUARD_MAX   = GW'(GUARD_SLOTS);
  localparam logic [GW-1:0] GUARD_LAST  = GW'(GUARD_SLOTS - 1);
  localparam logic [TW-1:0] LISTEN_MAX  = TW'(TIMEOUT_SLOTS);
  localparam logic [TW-1:0] LISTEN_LAST = TW'(TIMEOUT_SLOTS - 1);
  localparam logic [EW-1:0] ZERO_MAX    = EW'(END_SLOTS);
  localparam logic [EW-1:0] ZERO_LAST   = EW'(END_SLOTS - 1);
  localparam logic [RW-1:0] RX_MAX      = RW'(MAX_RX);
  localparam logic [RW-1:0] RX_LAST     = RW'(MAX_RX - 1);

  localparam logic [2:0] MODE_SNIFFER    = 3'b000;
  localparam logic [2:0] MODE_LISTEN     = 3'b011;
  localparam logic [2:0] MODE_READER_MOD = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_GUARD,
    S_LISTEN,
    S_RX,
    S_DONE
  } state_e;

  state_e        state, state_n;
  logic [3:0]    slot_cnt, slot_cnt_n;
  logic [7:0]    tx_len_q, tx_len_n;
  logic [7:0]    tx_slot, tx_slot_n;
  logic [GW-1:0] guard_cnt, guard_cnt_n;
  logic [TW-1:0] listen_cnt, listen_cnt_n;
  logic [EW-1:0] zero_cnt, zero_cnt_n;
  logic [RW-1:0] rx_count, rx_count_n;
  logic          mod_bit_n;
  logic          timeout_n;
  logic          slot_end;

  assign slot_end = (slot_cnt == 4'd15);

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_n      = state;
    slot_cnt_n   = slot_cnt + 4'd1;
    tx_len_n     = tx_len_q;
    tx_slot_n    = tx_slot;
    guard_cnt_n  = guard_cnt;
    listen_cnt_n = listen_cnt;
    zero_cnt_n   = zero_cnt;
    rx_count_n   = rx_count;
    mod_bit_n    = mod_bit;
    timeout_n    = timeout;
    tx_req       = 1'b0;
    rx_strobe    = 1'b0;
    rx_data      = 1'b0;
    rx_sof       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          tx_len_n     = tx_len;
          timeout_n    = 1'b0;
          tx_slot_n    = '0;
          guard_cnt_n  = '0;
          listen_cnt_n = '0;
          zero_cnt_n   = '0;
          rx_count_n   = '0;
          state_n      = (tx_len != 8'd0) ? S_TX : S_LISTEN;
        end
      end

      S_TX: begin
        if (slot_cnt == 4'd0) mod_bit_n = tx_bit;
        if (slot_end) begin
          if (tx_slot == tx_len_q - 8'd1) begin
            mod_bit_n = 1'b0;
            state_n   = S_GUARD;
          end else begin
            tx_req    = 1'b1;
            tx_slot_n = tx_slot + 8'd1;
          end
        end
      end

      S_GUARD: begin
        mod_bit_n = 1'b0;
        if (slot_end) begin
          if (guard_cnt == GUARD_LAST) state_n = S_LISTEN;
          else guard_cnt_n = (guard_cnt == GUARD_MAX) ? guard_cnt : guard_cnt + 1'b1;
        end
      end

      S_LISTEN: begin
        if (slot_end) begin
          if (rx_bit) begin
            rx_sof     = 1'b1;
            rx_strobe  = 1'b1;
            rx_data    = 1'b1;
            rx_count_n = RW'(1);
            zero_cnt_n = '0;
            state_n    = (MAX_RX <= 1) ? S_DONE : S_RX;
          end else if (listen_cnt == LISTEN_LAST) begin
            timeout_n = 1'b1;
            state_n   = S_DONE;
          end else begin
            listen_cnt_n = (listen_cnt == LISTEN_MAX) ? listen_cnt : listen_cnt + 1'b1;
          end
        end
      end

      S_RX: begin
        if (slot_end) begin
          rx_strobe  = 1'b1;
          rx_data    = rx_bit;
          rx_count_n = (rx_count == RX_MAX) ? rx_count : rx_count + 1'b1;
          if (rx_bit) zero_cnt_n = '0;
          else zero_cnt_n = (zero_cnt == ZERO_MAX) ? zero_cnt : zero_cnt + 1'b1;
          if ((!rx_bit && zero_cnt == ZERO_LAST) || rx_count == RX_LAST) state_n = S_DONE;
        end
      end

      S_DONE: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase

    // Abort beats everything, including a start seen in the same cycle; the sticky flag and
    // latched length keep their previous values.
    if (abort) begin
      state_n   = S_IDLE;
      mod_bit_n = 1'b0;
      timeout_n = timeout;
      tx_len_n  = tx_len_q;
      tx_req    = 1'b0;
      rx_strobe = 1'b0;
      rx_data   = 1'b0;
      rx_sof    = 1'b0;
    end

    // The slot timer parks at zero in IDLE so every exchange starts on a slot boundary.
    if (state == S_IDLE || state_n == S_IDLE) slot_cnt_n = 4'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge osc_clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      slot_cnt   <= 4'd0;
      tx_len_q   <= 8'd0;
      tx_slot    <= 8'd0;
      guard_cnt  <= '0;
      listen_cnt <= '0;
      zero_cnt   <= '0;
      rx_count   <= '0;
      mod_bit    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      slot_cnt   <= slot_cnt_n;
      tx_len_q   <= tx_len_n;
      tx_slot    <= tx_slot_n;
      guard_cnt  <= guard_cnt_n;
      listen_cnt <= listen_cnt_n;
      zero_cnt   <= zero_cnt_n;
      rx_count   <= rx_count_n;
      mod_bit    <= mod_bit_n;
      timeout    <= timeout_n;
    end
  end

  always_comb begin
    mod_type = MODE_SNIFFER;
    unique case (state)
      S_TX:                     mod_type = MODE_READER_MOD;
      S_GUARD, S_LISTEN, S_RX:  mod_type = MODE_LISTEN;
      default:                  mod_type = MODE_SNIFFER;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE) && !abort;

endmodule

// File: tb/tb_hf_reader_sequencer.sv
// Scoreboard bench for hf_reader_sequencer: a slot-level model predicts tx_req/rx_strobe/done
// events per exchange and a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_hf_reader_sequencer;

  localparam int GUARD = 8;
  localparam int TMO   = 512;
  localparam int ENDS  = 2;
  localparam int MAXRX = 256;
  localparam int NEVER = 1 << 30;

  logic       osc_clk = 1'b0;
  logic       nreset;
  logic       start, abort, tx_bit, rx_bit;
  logic [7:0] tx_len;
  logic [2:0] mod_type;
  logic       mod_bit, tx_req, rx_data, rx_strobe, rx_sof, busy, done, timeout;

  hf_reader_sequencer #(
    .GUARD_SLOTS(GUARD), .TIMEOUT_SLOTS(TMO), .END_SLOTS(ENDS), .MAX_RX(MAXRX)
  ) dut (
    .osc_clk(osc_clk), .nreset(nreset), .start(start), .abort(abort), .tx_len(tx_len),
    .tx_bit(tx_bit), .rx_bit(rx_bit), .mod_type(mod_type), .mod_bit(mod_bit),
    .tx_req(tx_req), .rx_data(rx_data), .rx_strobe(rx_strobe), .rx_sof(rx_sof),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 osc_clk = ~osc_clk;

  typedef enum logic [1:0] {K_TXREQ, K_STROBE, K_DONE} kind_e;
  typedef struct {
    kind_e      kind;
    int         rel;
    logic [1:0] data;
  } evt_t;

  evt_t exp_q[$];
  bit   tx_bits[$];
  bit   rx_slots[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   t0 = 0;
  bit   mon_en = 0;
  bit   done_seen = 0;

  always @(posedge osc_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input kind_e kind, input logic [1:0] data, input int rel);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_%s: got pulse at rel %0d want none", kind.name(), rel);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("evt_%s@%0d", e.kind.name(), e.rel),
            {26'd0, kind, 32'(rel), data}, {26'd0, e.kind, 32'(e.rel), e.data});
    end
  endtask

  // Monitor: every DUT pulse must match the next predicted event in kind, cycle and data.
  always @(negedge osc_clk) begin
    int rel;
    rel = cyc - t0;
    if (mon_en) begin
      if (tx_req === 1'b1) pop_cmp(K_TXREQ, 2'b00, rel);
      if (rx_strobe === 1'b1) pop_cmp(K_STROBE, {rx_sof, rx_data}, rel);
      else if (rx_sof !== 1'b0) check("sof_without_strobe", 64'(rx_sof), 64'd0);
      if (done === 1'b1) begin
        done_seen = 1'b1;
        pop_cmp(K_DONE, {1'b0, timeout}, rel);
      end
    end
  end

  function automatic bit rx_at(input int j);
    return (j < rx_slots.size()) ? rx_slots[j] : 1'b0;
  endfunction

  function automatic int listen_start(input int len);
    return (len > 0) ? 16 * (len + GUARD) : 0;
  endfunction

  // Slot-level reference: tx_req after every TX slot but the last, then the first modulated
  // listen slot opens RX, which runs until END zeros in a row or MAXRX bits.
  task automatic build_model(input int len, input int cut, output int done_rel, output bit exp_to);
    int ls, f, cnt, zeros, last;
    evt_t e;
    ls = listen_start(len);
    for (int s = 0; s < len - 1; s++) begin
      e = '{K_TXREQ, 16 * s + 15, 2'b00};
      if (e.rel < cut) exp_q.push_back(e);
    end
    f = -1;
    for (int j = 0; j < TMO; j++) if (f < 0 && rx_at(j)) f = j;
    if (f < 0) begin
      done_rel = ls + 16 * TMO;
      exp_to   = 1'b1;
    end else begin
      cnt = 0;
      zeros = 0;
      last = f;
      for (int j = f; j < f + MAXRX; j++) begin
        cnt++;
        zeros = rx_at(j) ? 0 : zeros + 1;
        e = '{K_STROBE, ls + 16 * j + 15, {(j == f), rx_at(j)}};
        if (e.rel < cut) exp_q.push_back(e);
        last = j;
        if (zeros >= ENDS || cnt >= MAXRX) break;
      end
      done_rel = ls + 16 * last + 16;
      exp_to   = 1'b0;
    end
    e = '{K_DONE, done_rel, {1'b0, exp_to}};
    if (e.rel < cut) exp_q.push_back(e);
  endtask

  // Runs one exchange from posedge+1; abort_rel/reset_rel >= 0 inject that event at that cycle.
  task automatic run_exchange(input int len, input int abort_rel, input int reset_rel);
    int  cut, done_rel, ls, limit, s;
    bit  exp_to;
    logic [2:0] exp_mode;
    logic       exp_mbit;
    cut = (abort_rel >= 0) ? abort_rel : (reset_rel >= 0) ? reset_rel : NEVER;
    exp_q.delete();
    build_model(len, cut, done_rel, exp_to);
    ls    = listen_start(len);
    limit = (cut != NEVER) ? cut + 40 : done_rel + 3;

    start  = 1'b1;
    tx_len = 8'(len);
    tx_bit = (tx_bits.size() > 0) ? tx_bits[0] : 1'b0;
    rx_bit = 1'b0;
    @(posedge osc_clk) #1;
    t0 = cyc;
    done_seen = 1'b0;
    for (int rel = 0; rel < limit; rel++) begin
      s      = rel / 16;
      start  = 1'b0;
      abort  = 1'b0;
      tx_bit = (s < len && s < tx_bits.size()) ? tx_bits[s] : 1'b0;
      rx_bit = (rel < ls) ? 1'($urandom_range(1)) : rx_at((rel - ls) / 16);
      if (cut == NEVER && rel == 5) begin
        start  = 1'b1;
        tx_len = 8'($urandom);
      end
      if (rel == abort_rel) begin
        abort = 1'b1;
        start = 1'b1;
      end
      if (reset_rel >= 0 && rel == reset_rel + 2) nreset = 1'b1;
      if (rel == reset_rel) begin
        #2 nreset = 1'b0;
        #1;
        check("rst_mod_type", 64'(mod_type), 64'd0);
        check("rst_mod_bit", 64'(mod_bit), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobe", 64'(rx_strobe), 64'd0);
      end
      @(negedge osc_clk);
      if (rel == 0) check("timeout_cleared_on_start", 64'(timeout), 64'd0);
      if (rel < cut && rel % 16 == 8) begin
        exp_mode = (rel < 16 * len) ? 3'b100 : 3'b011;
        exp_mbit = (rel < 16 * len && s < tx_bits.size()) ? tx_bits[s] : 1'b0;
        check($sformatf("mod_type@%0d", rel), 64'(mod_type), 64'(exp_mode));
        check($sformatf("mod_bit@%0d", rel), 64'(mod_bit), 64'(exp_mbit));
        check($sformatf("busy@%0d", rel), 64'(busy), 64'd1);
      end
      if (abort_rel >= 0 && rel == abort_rel + 1) begin
        check("abort_idle_busy", 64'(busy), 64'd0);
        check("abort_mod_type", 64'(mod_type), 64'd0);
        check("abort_mod_bit", 64'(mod_bit), 64'd0);
      end
      @(posedge osc_clk) #1;
    end
    start = 1'b0;
    abort = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_seen", 64'(done_seen), (cut == NEVER) ? 64'd1 : 64'd0);
    check("idle_at_end", 64'(busy), 64'd0);
    if (cut == NEVER) check("timeout_flag", 64'(timeout), 64'(exp_to));
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    tx_len = 8'd0;
    tx_bit = 1'b0;
    rx_bit = 1'b0;
    repeat (3) @(posedge osc_clk);
    @(negedge osc_clk);
    check("reset_mod_type", 64'(mod_type), 64'd0);
    check("reset_mod_bit", 64'(mod_bit), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_timeout", 64'(timeout), 64'd0);
    check("reset_pulses", 64'({tx_req, rx_strobe, rx_sof, done}), 64'd0);
    @(posedge osc_clk) #1;
    nreset = 1'b1;
    mon_en = 1'b1;
    @(posedge osc_clk) #1;

    // Directed reader exchange with a five-slot silent prefix before the tag answers.
    tx_bits  = '{1'b1, 1'b0, 1'b1};
    rx_slots = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    run_exchange(3, -1, -1);

    // Listen-only exchange that times out, then a normal one that clears the sticky flag.
    tx_bits.delete();
    rx_slots.delete();
    run_exchange(0, -1, -1);
    tx_bits  = '{1'b0, 1'b1};
    rx_slots = '{1'b1, 1'b0, 1'b0};
    run_exchange(2, -1, -1);

    // Continuous modulation hits the MAX_RX cap.
    tx_bits = '{1'b1};
    rx_slots.delete();
    for (int i = 0; i < 300; i++) rx_slots.push_back(1'b1);
    run_exchange(1, -1, -1);

    // Abort in TX slot 1 and in the middle of RX, each with a start in the same cycle.
    tx_bits  = '{1'b1, 1'b1, 1'b0, 1'b1};
    rx_slots = '{1'b1, 1'b1};
    run_exchange(4, 16 + 5, -1);
    tx_bits  = '{1'b1, 1'b0};
    rx_slots = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    run_exchange(2, listen_start(2) + 16 * 3 + 7, -1);

    // Start and abort together in IDLE: the start is dropped.
    start  = 1'b1;
    abort  = 1'b1;
    tx_len = 8'd3;
    @(posedge osc_clk) #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge osc_clk);
    check("start_abort_idle_busy", 64'(busy), 64'd0);
    check("start_abort_idle_mode", 64'(mod_type), 64'd0);
    repeat (20) @(posedge osc_clk);
    #1;

    // Reset asserted in the middle of RX.
    tx_bits  = '{1'b0};
    rx_slots = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    run_exchange(1, -1, listen_start(1) + 16 * 2 + 9);
    @(posedge osc_clk) #1;

    // Randomized exchanges.
    for (int n = 0; n < 8; n++) begin
      int len;
      len = $urandom_range(1, 5);
      tx_bits.delete();
      rx_slots.delete();
      for (int i = 0; i < len; i++) tx_bits.push_back(1'($urandom_range(1)));
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) rx_slots.push_back(1'b0);
      rx_slots.push_back(1'b1);
      for (int i = 0; i < 10; i++) rx_slots.push_back($urandom_range(0, 9) < 6);
      run_exchange(len, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
